// File: rtl/memctrl_line.sv
// Byte-serial RAM controller: data-port load/store and instruction line fill; MEMCTRL_RR_ARB_EN selects round-robin arbitration.
// Latency: k-byte read valid k+1 cycles after accept, store done k cycles after accept plus io_buffer_full stall cycles.
// Backpressure: io_buffer_full stalls store bytes, rdy_in low freezes everything, requests are taken only while idle.
module memctrl_line #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    fetch_req,
  input  logic [ADDR_W-1:0]       fetch_addr,
  output logic                    fetch_valid,
  output logic [8*LINE_BYTES-1:0] line_data,
  input  logic                    ls_req,
  input  logic                    ls_store,
  input  logic [2:0]              ls_op,
  input  logic [ADDR_W-1:0]       ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_valid,
  output logic [31:0]             ls_rdata,
  output logic                    busy,
  input  logic                    io_buffer_full,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_wr,
  output logic [7:0]              ram_dout,
  input  logic [7:0]              ram_din
);

  localparam int IDX_W  = $clog2(LINE_BYTES + 2);
  localparam int LINE_W = 8 * LINE_BYTES;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, len, last, rx_idx;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [LINE_W-1:0] rx_q, rx_next;
  logic [31:0]       load_ext;
  logic              ls_ok, fetch_ok, grant_ls, grant_fetch;
  logic              issuing, capture, rx_done;

  always_comb begin
    len = IDX_W'(4);
    if (state_q == FETCH) begin
      len = IDX_W'(LINE_BYTES);
    end else begin
      case (op_q[1:0])
        2'b00:   len = IDX_W'(1);
        2'b01:   len = IDX_W'(2);
        default: len = IDX_W'(4);
      endcase
    end
  end

  assign last = len + IDX_W'(1);

  // A flush cancels speculative work only; stores are already committed.
  assign ls_ok    = ls_req & (ls_store | ~flush_in);
  assign fetch_ok = fetch_req & ~flush_in;

`ifdef MEMCTRL_RR_ARB_EN
  logic rr_q;  // 1: fetch port wins the next conflict

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_q <= 1'b0;
    end else if (rdy_in && state_q == IDLE) begin
      if (grant_ls) begin
        rr_q <= 1'b1;
      end else if (grant_fetch) begin
        rr_q <= 1'b0;
      end
    end
  end

  assign grant_ls = ls_ok & ~(fetch_ok & rr_q);
`else
  assign grant_ls = ls_ok;
`endif
  assign grant_fetch = fetch_ok & ~grant_ls;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (grant_ls) begin
          state_d = ls_store ? STORE : LOAD;
          base_d  = ls_addr;
          op_d    = ls_op;
          wdata_d = ls_wdata;
        end else if (grant_fetch) begin
          state_d = FETCH;
          base_d  = fetch_addr & ~ADDR_W'(LINE_BYTES - 1);
        end
      end
      LOAD, FETCH: begin
        if (flush_in || idx_q == last) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      STORE: begin
        if (idx_q == len) begin
          state_d = IDLE;
        end else if (!io_buffer_full) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
    end
  end

  // Address phase covers idx 0..k-1; reads then need one more cycle for the RAM data.
  assign issuing     = (state_q != IDLE) && (idx_q < len);
  assign ram_addr    = issuing ? base_q + ADDR_W'(idx_q) : '0;
  assign ram_wr      = issuing && (state_q == STORE) && !io_buffer_full && rdy_in;
  assign ram_dout    = (issuing && state_q == STORE) ? wdata_q[{idx_q[1:0], 3'b000} +: 8] : 8'h00;
  assign ls_valid    = rdy_in && (((state_q == LOAD) && (idx_q == last)) ||
                                  ((state_q == STORE) && (idx_q == len)));
  assign fetch_valid = rdy_in && (state_q == FETCH) && (idx_q == last);
  assign busy        = (state_q != IDLE);

  // ram_din in cycle i carries the byte addressed in cycle i-1.
  assign capture = ((state_q == LOAD) || (state_q == FETCH)) && (idx_q != '0) && (idx_q <= len);
  assign rx_idx  = idx_q - IDX_W'(1);
  assign rx_done = capture && (idx_q == len) && !flush_in;

  always_comb begin
    rx_next = rx_q;
    if (capture) begin
      rx_next[{rx_idx, 3'b000} +: 8] = ram_din;
    end
  end

  always_comb begin
    case (op_q)
      3'b000:  load_ext = {{24{rx_next[7]}}, rx_next[7:0]};
      3'b001:  load_ext = {{16{rx_next[15]}}, rx_next[15:0]};
      3'b100:  load_ext = {24'h0, rx_next[7:0]};
      3'b101:  load_ext = {16'h0, rx_next[15:0]};
      default: load_ext = rx_next[31:0];
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_q      <= '0;
      line_data <= '0;
      ls_rdata  <= '0;
    end else if (rdy_in) begin
      rx_q <= rx_next;
      if (rx_done && state_q == FETCH) begin
        line_data <= rx_next;
      end
      if (rx_done && state_q == LOAD) begin
        ls_rdata <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_memctrl_line.sv
// Directed bench for memctrl_line: byte-wide RAM model, hand-computed expectations per cycle.
module tb_memctrl_line;

  logic         clk_in = 1'b0;
  logic         rst_in, rdy_in, flush_in, fetch_req, ls_req, ls_store, io_buffer_full;
  logic [31:0]  fetch_addr, ls_addr, ls_wdata, ls_rdata, ram_addr;
  logic [2:0]   ls_op;
  logic [127:0] line_data, exp_line;
  logic         fetch_valid, ls_valid, busy, ram_wr, seen;
  logic [7:0]   ram_dout, ram_din;
  logic [31:0]  exp_arb;

  bit [7:0] rom   [0:262143];
  bit [7:0] wmem  [0:262143];
  bit       wflag [0:262143];

  int checks = 0;
  int errors = 0;

  memctrl_line #(.LINE_BYTES(16), .ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .line_data(line_data), .ls_req(ls_req), .ls_store(ls_store), .ls_op(ls_op),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .busy(busy), .io_buffer_full(io_buffer_full), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk_in = ~clk_in;

  // RAM: read data one cycle after its address, writes logged separately.
  always @(posedge clk_in) begin
    ram_din <= rom[ram_addr[17:0]];
    if (ram_wr) begin
      wmem[ram_addr[17:0]]  <= ram_dout;
      wflag[ram_addr[17:0]] <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_in);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rom[32'h100] = 8'h11; rom[32'h101] = 8'h22; rom[32'h102] = 8'h33; rom[32'h103] = 8'h44;
    rom[32'h80]  = 8'hF0;
    exp_line = '0;
    for (int i = 0; i < 16; i++) begin
      rom[32'h1230 + i] = 8'h50 + 8'(i);
      exp_line[8*i +: 8] = 8'h50 + 8'(i);
    end
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    ls_req = 1'b0; ls_store = 1'b0; ls_op = '0; ls_addr = '0; ls_wdata = '0; io_buffer_full = 1'b0;

    // Reset state
    smp;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ram_wr", ram_wr, 1'b0);
    chk32("rst_ram_addr", ram_addr, 32'h0);
    chk8("rst_ram_dout", ram_dout, 8'h00);
    chk1("rst_ls_valid", ls_valid, 1'b0);
    chk1("rst_fetch_valid", fetch_valid, 1'b0);
    chk32("rst_ls_rdata", ls_rdata, 32'h0);
    chkw("rst_line_data", line_data, 128'h0);
    step; rst_in = 1'b1;

    // lw 0x100
    ls_req = 1'b1; ls_store = 1'b0; ls_op = 3'b010; ls_addr = 32'h100;
    step; ls_req = 1'b0; ls_addr = 32'hDEAD_BEEF; ls_op = 3'b000;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step;
      smp;
      chk32("lw_addr", ram_addr, 32'h100 + 32'(c));
      chk1("lw_wr", ram_wr, 1'b0);
    end
    step; smp; chk1("lw_c4_valid", ls_valid, 1'b0);
    step; smp; chk1("lw_c5_valid", ls_valid, 1'b1); chk32("lw_data", ls_rdata, 32'h44332211);
    step; smp; chk1("lw_c6_busy", busy, 1'b0); chk1("lw_c6_valid", ls_valid, 1'b0);
    chk32("lw_idle_addr", ram_addr, 32'h0);

    // lb then lbu at 0x80
    ls_req = 1'b1; ls_op = 3'b000; ls_addr = 32'h80;
    step; ls_req = 1'b0;
    smp; chk32("lb_addr", ram_addr, 32'h80);
    step; smp; chk1("lb_c1_valid", ls_valid, 1'b0);
    step; smp; chk1("lb_c2_valid", ls_valid, 1'b1); chk32("lb_data", ls_rdata, 32'hFFFFFFF0);
    step; smp; chk1("lb_c3_busy", busy, 1'b0);
    ls_req = 1'b1; ls_op = 3'b100; ls_addr = 32'h80;
    step; ls_req = 1'b0;
    step; step; smp; chk1("lbu_valid", ls_valid, 1'b1); chk32("lbu_data", ls_rdata, 32'h000000F0);
    step; smp; chk1("lbu_idle", busy, 1'b0);

    // sw 0x30000 with io_buffer_full stall in cycles 1-2, flush ignored in cycle 4
    ls_req = 1'b1; ls_store = 1'b1; ls_op = 3'b010; ls_addr = 32'h30000; ls_wdata = 32'hA1B2C3D4;
    step; ls_req = 1'b0; ls_store = 1'b0; ls_wdata = 32'h0;
    smp; chk1("sw_c0_wr", ram_wr, 1'b1); chk32("sw_c0_addr", ram_addr, 32'h30000); chk8("sw_c0_dout", ram_dout, 8'hD4);
    step; io_buffer_full = 1'b1; smp; chk1("sw_c1_wr", ram_wr, 1'b0);
    step; smp; chk1("sw_c2_wr", ram_wr, 1'b0); chk1("sw_c2_valid", ls_valid, 1'b0);
    step; io_buffer_full = 1'b0;
    smp; chk1("sw_c3_wr", ram_wr, 1'b1); chk32("sw_c3_addr", ram_addr, 32'h30001); chk8("sw_c3_dout", ram_dout, 8'hC3);
    step; flush_in = 1'b1; smp; chk1("sw_c4_wr", ram_wr, 1'b1); chk8("sw_c4_dout", ram_dout, 8'hB2);
    step; flush_in = 1'b0;
    smp; chk32("sw_c5_addr", ram_addr, 32'h30003); chk8("sw_c5_dout", ram_dout, 8'hA1);
    step; smp; chk1("sw_c6_valid", ls_valid, 1'b1); chk1("sw_c6_wr", ram_wr, 1'b0);
    chk32("sw_rdata_held", ls_rdata, 32'h000000F0);
    step; smp; chk1("sw_c7_busy", busy, 1'b0);
    chk32("sw_mem", {wmem[32'h30003], wmem[32'h30002], wmem[32'h30001], wmem[32'h30000]}, 32'hA1B2C3D4);

    // Line fill at 0x1234
    fetch_req = 1'b1; fetch_addr = 32'h1234;
    step; fetch_req = 1'b0; fetch_addr = 32'h0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step;
      smp;
      chk32("fetch_addr", ram_addr, 32'h1230 + 32'(c));
    end
    step; smp; chk1("fetch_c16_valid", fetch_valid, 1'b0);
    step; smp; chk1("fetch_c17_valid", fetch_valid, 1'b1); chkw("fetch_line", line_data, exp_line);
    step; smp; chk1("fetch_c18_busy", busy, 1'b0);

    // Line fill aborted by flush in cycle 5
    fetch_req = 1'b1; fetch_addr = 32'h1234;
    step; fetch_req = 1'b0;
    repeat (4) step;
    step; flush_in = 1'b1; smp; chk1("flush_c5_busy", busy, 1'b1);
    step; flush_in = 1'b0; smp; chk1("flush_c6_busy", busy, 1'b0);
    seen = fetch_valid;
    for (int i = 0; i < 15; i++) begin
      step; smp;
      if (fetch_valid) seen = 1'b1;
    end
    chk1("flush_no_valid", seen, 1'b0);
    chkw("flush_line_held", line_data, exp_line);

    // Flush in IDLE blocks load/fetch but still accepts a store
    ls_req = 1'b1; ls_store = 1'b0; ls_op = 3'b010; ls_addr = 32'h100; fetch_req = 1'b1; flush_in = 1'b1;
    step; smp; chk1("flush_idle_block", busy, 1'b0);
    ls_store = 1'b1; ls_op = 3'b000; ls_addr = 32'h40; ls_wdata = 32'h77; fetch_req = 1'b0;
    step; ls_req = 1'b0; ls_store = 1'b0; flush_in = 1'b0;
    smp; chk1("sb_flush_busy", busy, 1'b1); chk1("sb_wr", ram_wr, 1'b1);
    chk32("sb_addr", ram_addr, 32'h40); chk8("sb_dout", ram_dout, 8'h77);
    step; smp; chk1("sb_valid", ls_valid, 1'b1);
    step; smp; chk1("sb_idle", busy, 1'b0);

    // sh 0x50 with rdy_in low during a write cycle and during the completion cycle
    ls_req = 1'b1; ls_store = 1'b1; ls_op = 3'b001; ls_addr = 32'h50; ls_wdata = 32'h0000BEEF;
    step; ls_req = 1'b0; ls_store = 1'b0;
    smp; chk8("sh_c0_dout", ram_dout, 8'hEF);
    step; rdy_in = 1'b0; smp; chk1("frz_wr", ram_wr, 1'b0);
    step; rdy_in = 1'b1; smp; chk1("sh_c2_wr", ram_wr, 1'b1); chk32("sh_c2_addr", ram_addr, 32'h51);
    chk8("sh_c2_dout", ram_dout, 8'hBE);
    step; rdy_in = 1'b0; smp; chk1("frz_no_valid", ls_valid, 1'b0);
    step; rdy_in = 1'b1; smp; chk1("sh_valid", ls_valid, 1'b1);
    step; smp; chk1("sh_idle", busy, 1'b0);
    chk8("sh_mem_hi", wmem[32'h51], 8'hBE);

    // Reset in the middle of a store
    ls_req = 1'b1; ls_store = 1'b1; ls_op = 3'b010; ls_addr = 32'h60; ls_wdata = 32'h11223344;
    step; ls_req = 1'b0; ls_store = 1'b0;
    smp; chk1("rstop_c0_wr", ram_wr, 1'b1);
    step; rst_in = 1'b0;
    smp; chk1("rstop_busy", busy, 1'b0); chk1("rstop_wr", ram_wr, 1'b0);
    chk32("rstop_rdata", ls_rdata, 32'h0); chkw("rstop_line", line_data, 128'h0);
    step; rst_in = 1'b1;
    repeat (6) begin step; smp; end
    chk1("rstop_b0_written", wflag[32'h60], 1'b1);
    chk1("rstop_b1_dropped", wflag[32'h61], 1'b0);

    // Two simultaneous data/fetch requests after reset
    ls_req = 1'b1; ls_store = 1'b0; ls_op = 3'b000; ls_addr = 32'h80;
    fetch_req = 1'b1; fetch_addr = 32'h1230;
    step; ls_req = 1'b0; fetch_req = 1'b0;
    smp; chk32("arb1_addr", ram_addr, 32'h80);
    step; step; step; smp; chk1("arb1_idle", busy, 1'b0);
    ls_req = 1'b1; fetch_req = 1'b1;
    step; ls_req = 1'b0; fetch_req = 1'b0;
`ifdef MEMCTRL_RR_ARB_EN
    exp_arb = 32'h1230;
`else
    exp_arb = 32'h80;
`endif
    smp; chk32("arb2_addr", ram_addr, exp_arb);
    for (int i = 0; i < 40 && busy; i++) begin
      step; smp;
    end
    chk1("arb2_done", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
